// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load-type codes, datapath width defaults, WB state encoding.
// No logic; pure types and constants.
// No flow control of its own.
package cpu_pkg;

  localparam int XLEN_DFLT    = 32;
  localparam int RADDR_W_DFLT = 5;

  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    WAIT_LOAD = 2'd1,
    COMMIT    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/load_extract.sv
// Load data aligner: picks byte/half/word from a word-aligned read and extends it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module load_extract
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DFLT
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      load_type,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword selection uses only the upper offset bit; misaligned halves are not supported.
  always_comb begin
    byte_sel = rdata[8*off +: 8];
    half_sel = rdata[16*off[1] +: 16];
    case (load_type)
      LT_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LT_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      LT_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      LT_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;  // LW and undefined codes pass the full word
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers the MEM-stage instruction, waits for late load data, drives RF write port.
// Latency: one cycle from capture to write (COMMIT), plus however long load data takes to arrive.
// Backpressure: wb_stall holds MEM and earlier stages while a load waits for dmem_rvalid.
module wb_stage
  import cpu_pkg::*;
#(
  parameter int XLEN    = XLEN_DFLT,
  parameter int RADDR_W = RADDR_W_DFLT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               m_valid,
  input  logic               m_reg_we,
  input  logic [RADDR_W-1:0] m_rd,
  input  logic [XLEN-1:0]    m_result,
  input  logic               m_is_load,
  input  logic [2:0]         m_load_type,
  input  logic [XLEN-1:0]    dmem_rdata,
  input  logic               dmem_rvalid,
  output logic               wb_stall,
  output logic               we3,
  output logic [RADDR_W-1:0] addr3,
  output logic [XLEN-1:0]    write3,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]    fwd_data,
  output logic [31:0]        instret
);

  wb_state_t          state;
  logic               reg_we_q;
  logic [RADDR_W-1:0] rd_q;
  logic [XLEN-1:0]    data_q;
  logic [1:0]         off_q;
  logic [2:0]         lt_q;
  logic [RADDR_W-1:0] addr3_q;
  logic [XLEN-1:0]    write3_q;
  logic [31:0]        instret_q;

  logic               capture;
  logic [1:0]         ext_off;
  logic [2:0]         ext_type;
  logic [XLEN-1:0]    ext_data;

  assign wb_stall = (state == WAIT_LOAD);
  assign capture  = m_valid && !wb_stall;

  // A waiting load uses its latched alignment; otherwise the incoming instruction's fields.
  always_comb begin
    ext_off  = m_result[1:0];
    ext_type = m_load_type;
    if (state == WAIT_LOAD) begin
      ext_off  = off_q;
      ext_type = lt_q;
    end
  end

  load_extract #(.XLEN(XLEN)) u_extract (
    .rdata     (dmem_rdata),
    .off       (ext_off),
    .load_type (ext_type),
    .data      (ext_data)
  );

  // Stage FSM, instruction registers, held write-port values and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= EMPTY;
      reg_we_q  <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      off_q     <= '0;
      lt_q      <= '0;
      addr3_q   <= '0;
      write3_q  <= '0;
      instret_q <= '0;
    end else begin
      if (state == COMMIT) begin
        instret_q <= instret_q + 32'd1;
        addr3_q   <= rd_q;
        write3_q  <= data_q;
      end
      case (state)
        EMPTY, COMMIT: begin
          if (capture) begin
            reg_we_q <= m_reg_we;
            rd_q     <= m_rd;
            off_q    <= m_result[1:0];
            lt_q     <= m_load_type;
            if (!m_is_load) begin
              data_q <= m_result;
              state  <= COMMIT;
            end else if (dmem_rvalid) begin
              data_q <= ext_data;
              state  <= COMMIT;
            end else begin
              state  <= WAIT_LOAD;
            end
          end else begin
            state <= EMPTY;
          end
        end
        WAIT_LOAD: begin
          if (dmem_rvalid) begin
            data_q <= ext_data;
            state  <= COMMIT;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Write port is live only in COMMIT; outside it the address/data hold the last commit.
  always_comb begin
    we3    = (state == COMMIT) && reg_we_q && (rd_q != '0);
    addr3  = addr3_q;
    write3 = write3_q;
    if (state == COMMIT) begin
      addr3  = rd_q;
      write3 = data_q;
    end
  end

  assign fwd_valid = (state != EMPTY) && reg_we_q && (rd_q != '0);
  assign fwd_rd    = rd_q;
  assign fwd_data  = data_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic        m_reg_we;
  logic [4:0]  m_rd;
  logic [31:0] m_result;
  logic        m_is_load;
  logic [2:0]  m_load_type;
  logic [31:0] dmem_rdata;
  logic        dmem_rvalid;
  logic        wb_stall;
  logic        we3;
  logic [4:0]  addr3;
  logic [31:0] write3;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [31:0] instret;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] exp_ret;
  logic [4:0]  last_rd;
  logic [31:0] last_wdata;

  wb_stage #(.XLEN(32), .RADDR_W(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .m_valid     (m_valid),
    .m_reg_we    (m_reg_we),
    .m_rd        (m_rd),
    .m_result    (m_result),
    .m_is_load   (m_is_load),
    .m_load_type (m_load_type),
    .dmem_rdata  (dmem_rdata),
    .dmem_rvalid (dmem_rvalid),
    .wb_stall    (wb_stall),
    .we3         (we3),
    .addr3       (addr3),
    .write3      (write3),
    .fwd_valid   (fwd_valid),
    .fwd_rd      (fwd_rd),
    .fwd_data    (fwd_data),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Expected loaded value from byte-lane arithmetic.
  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [2:0] lt);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * int'(off))) & 32'hFF;
    h = (w >> (off[1] ? 16 : 0)) & 32'hFFFF;
    case (lt)
      3'd0:    return (b >= 128) ? b - 256 : b;
      3'd1:    return (h >= 32768) ? h - 65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic junk_inputs();
    m_reg_we    = 1'($urandom);
    m_rd        = 5'($urandom);
    m_result    = $urandom;
    m_is_load   = 1'($urandom);
    m_load_type = 3'($urandom);
  endtask

  // Present one instruction (assumes stage can capture now), wait out any load delay,
  // then check the commit cycle. delay = number of cycles spent in WAIT_LOAD.
  task automatic issue(input string tag, input logic [4:0] rd, input logic we, input logic ld,
                       input logic [2:0] lt, input logic [31:0] res, input logic [31:0] rdata,
                       input int delay);
    logic [31:0] expd;
    logic        exp_we;
    expd   = ld ? exp_load(rdata, res[1:0], lt) : res;
    exp_we = we && (rd != 5'd0);
    m_valid     = 1'b1;
    m_reg_we    = we;
    m_rd        = rd;
    m_result    = res;
    m_is_load   = ld;
    m_load_type = lt;
    dmem_rvalid = ld && (delay == 0);
    dmem_rdata  = (ld && delay == 0) ? rdata : $urandom;
    step();
    if (ld && delay > 0) begin
      for (int d = 1; d <= delay; d++) begin
        chk({tag, ".stall"}, 32'(wb_stall), 32'd1);
        chk({tag, ".we3_wait"}, 32'(we3), 32'd0);
        m_valid = 1'($urandom);
        junk_inputs();
        dmem_rvalid = (d == delay);
        dmem_rdata  = (d == delay) ? rdata : $urandom;
        step();
      end
    end
    m_valid     = 1'b0;
    dmem_rvalid = 1'b0;
    chk({tag, ".stall_c"}, 32'(wb_stall), 32'd0);
    chk({tag, ".we3"}, 32'(we3), 32'(exp_we));
    chk({tag, ".addr3"}, 32'(addr3), 32'(rd));
    chk({tag, ".write3"}, write3, expd);
    chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'(exp_we));
    if (exp_we) begin
      chk({tag, ".fwd_rd"}, 32'(fwd_rd), 32'(rd));
      chk({tag, ".fwd_data"}, fwd_data, expd);
    end
    chk({tag, ".instret"}, instret, exp_ret);
    exp_ret    = exp_ret + 32'd1;
    last_rd    = rd;
    last_wdata = expd;
  endtask

  task automatic idle(input string tag);
    m_valid     = 1'b0;
    dmem_rvalid = 1'($urandom);  // stray rvalid must be ignored
    dmem_rdata  = $urandom;
    step();
    dmem_rvalid = 1'b0;
    chk({tag, ".we3"}, 32'(we3), 32'd0);
    chk({tag, ".stall"}, 32'(wb_stall), 32'd0);
    chk({tag, ".fwd_valid"}, 32'(fwd_valid), 32'd0);
    chk({tag, ".addr3_hold"}, 32'(addr3), 32'(last_rd));
    chk({tag, ".write3_hold"}, write3, last_wdata);
    chk({tag, ".instret"}, instret, exp_ret);
  endtask

  initial begin
    reset = 1'b1;
    m_valid = 1'b0; m_reg_we = 1'b0; m_rd = '0; m_result = '0;
    m_is_load = 1'b0; m_load_type = '0; dmem_rdata = '0; dmem_rvalid = 1'b0;
    exp_ret = '0; last_rd = '0; last_wdata = '0;
    step();
    step();
    reset = 1'b0;

    // reset state
    chk("rst.we3", 32'(we3), 32'd0);
    chk("rst.addr3", 32'(addr3), 32'd0);
    chk("rst.write3", write3, 32'd0);
    chk("rst.stall", 32'(wb_stall), 32'd0);
    chk("rst.fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst.fwd_rd", 32'(fwd_rd), 32'd0);
    chk("rst.fwd_data", fwd_data, 32'd0);
    chk("rst.instret", instret, 32'd0);

    // simple ALU write
    issue("alu5", 5'd5, 1'b1, 1'b0, 3'd0, 32'h1234_5678, 32'h0, 0);
    idle("alu5_after");
    chk("alu5.instret_abs", instret, 32'd1);

    // byte loads with data in the capture cycle, back-to-back
    issue("lb", 5'd6, 1'b1, 1'b1, 3'b000, 32'h0000_1003, 32'h80FF_7F01, 0);
    chk("lb.value", last_wdata, 32'hFFFF_FF80);
    issue("lbu", 5'd7, 1'b1, 1'b1, 3'b100, 32'h0000_1003, 32'h80FF_7F01, 0);
    chk("lbu.value", last_wdata, 32'h0000_0080);

    // halfword load arriving 3 cycles late
    issue("lh_late", 5'd8, 1'b1, 1'b1, 3'b001, 32'h0000_2002, 32'h8001_0000, 3);
    chk("lh_late.value", last_wdata, 32'hFFFF_8001);
    idle("lh_after");

    // four back-to-back writes
    for (int i = 1; i <= 4; i++)
      issue($sformatf("b2b%0d", i), 5'(i), 1'b1, 1'b0, 3'd0, 32'hA000_0000 + 32'(i), 32'h0, 0);
    idle("b2b_after");
    chk("b2b.instret_abs", instret, 32'd8);

    // write to x0 retires without a register write
    issue("x0", 5'd0, 1'b1, 1'b0, 3'd0, 32'hDEAD_BEEF, 32'h0, 0);
    idle("x0_after");

    // reset while waiting on a load, then a late rvalid
    m_valid = 1'b1; m_reg_we = 1'b1; m_rd = 5'd9; m_result = 32'h0000_0000;
    m_is_load = 1'b1; m_load_type = 3'b010; dmem_rvalid = 1'b0;
    step();
    chk("rstwait.stall_pre", 32'(wb_stall), 32'd1);
    reset = 1'b1;
    m_valid = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;  // reset wins over both
    step();
    reset = 1'b0;
    m_valid = 1'b0;
    dmem_rvalid = 1'b1;
    exp_ret = '0; last_rd = '0; last_wdata = '0;
    chk("rstwait.stall", 32'(wb_stall), 32'd0);
    chk("rstwait.fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rstwait.we3", 32'(we3), 32'd0);
    step();
    dmem_rvalid = 1'b0;
    chk("rstwait.we3_late", 32'(we3), 32'd0);
    chk("rstwait.stall_late", 32'(wb_stall), 32'd0);
    chk("rstwait.instret", instret, 32'd0);
    step();
    chk("rstwait.we3_late2", 32'(we3), 32'd0);
    chk("rstwait.write3", write3, 32'd0);

    // randomized instruction stream
    for (int n = 0; n < 200; n++) begin
      logic ld;
      ld = 1'($urandom);
      if ($urandom_range(0, 9) < 3) idle($sformatf("ridle%0d", n));
      issue($sformatf("rnd%0d", n), 5'($urandom), 1'($urandom), ld, 3'($urandom), $urandom,
            $urandom, ld ? int'($urandom_range(0, 3)) : 0);
    end
    idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
